hazard_unit_mc: RTL and testbench
=================================

# hazard_unit_mc

Parametrised pipeline hazard unit for the five-stage MIPS core, successor to the single-cycle combinational hazard logic. It still produces the ID/EX forwarding selects and the load-use and branch stalls. It adds three things: a sequential tracker for the multi-cycle multiply/divide unit, a data-memory wait handshake that freezes the whole pipe, and register-zero forwarding suppression. It sits beside the datapath, reading stage register addresses and control bits and driving the per-stage stall/flush enables.

## Interface
- `REG_W`, 5, register address width
- `MD_LATENCY`, 4, cycles the mult/div unit is busy after start (≥2)
- `CNT_W`, 16, width of the stall-cycle counter (used only with HAZARD_STALL_CNT_EN)

Ports (all synchronous to `clk`):
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `branchID`, `jumpRegID` in 1: ID instruction is a branch (compares rs, rt) / `jr` (reads rs only)
- `rsID`, `rtID`, `rsEX`, `rtEX`, `writeRegEX`, `writeRegMEM`, `writeRegWB` in REG_W: stage register addresses
- `memToRegEX`, `memToRegMEM` in 1: load in EX / MEM
- `regWriteEX`, `regWriteMEM`, `regWriteWB` in 1: stage writes register file
- `mdStartEX` in 1: mult/div instruction in EX (start request)
- `mdReadID` in 1: `mfhi`/`mflo` in ID
- `memReqMEM`, `memReadyMEM` in 1: data-memory access in MEM / memory response valid
- `stallFE`, `stallID`, `stallEX`, `stallMEM` out 1: hold stage register
- `flushEX`, `flushMEM`, `flushWB` out 1: insert bubble into stage register
- `forwardAID`, `forwardBID` out 1: ID comparator operands from MEM result
- `forwardAEX`, `forwardBEX` out 2: 10 = MEM, 01 = WB, 00 = register file
- `mdBusy` out 1: registered, mult/div unit busy
- `stallCount` out CNT_W: saturating count of cycles with stallFE = 1

## Operation
- Forwarding: same priority as before (MEM over WB). A select is asserted only when the matched address is non-zero. forwardAID/BID = (rsID/rtID == writeRegMEM) && regWriteMEM && address ≠ 0.
- memStall = memReqMEM && !memReadyMEM. It asserts stallFE/ID/EX/MEM and flushWB. It has top priority and masks every other stall/flush.
- mdStruct = mdStartEX && mdBusy. It asserts stallFE/ID/EX and flushMEM.
- lwStall = memToRegEX && writeRegEX ≠ 0 && (writeRegEX == rsID || writeRegEX == rtID).
- branchStall uses the operands read: rs and rt for branchID, rs only for jumpRegID. It fires on a regWriteEX match to writeRegEX, or a memToRegMEM match to writeRegMEM, with address ≠ 0.
- mdReadStall = mdReadID && mdBusy.
- Front stall = lwStall | branchStall | mdReadStall. It asserts stallFE, stallID and flushEX, and applies only when neither memStall nor mdStruct is active.
- Mult/div FSM:
  - IDLE → BUSY when mdStartEX && !stallEX. Counter loads MD_LATENCY−1.
  - BUSY: counter decrements every cycle, including during memStall. At counter == 0 it returns to IDLE.
  - mdBusy = (state == BUSY).
  - A start that arrives while BUSY is held by mdStruct until IDLE. It is accepted in the IDLE cycle.

## Timing
- Stall, flush and forward outputs are combinational from the current-cycle inputs plus registered state. There is zero latency from an input change.
- mdBusy rises the cycle after start acceptance and stays high exactly MD_LATENCY−1 cycles.
- State updates on the rising clk edge.
- Reset values:
  - FSM IDLE, counter 0, mdBusy 0, stallCount 0.
  - With mdBusy = 0, the outputs follow the combinational rules.
  - Reset mid-BUSY aborts the operation. mdBusy is 0 the next cycle.
- Simultaneous events:
  - memStall with lwStall: only the memStall outputs are asserted, with flushEX = 0.
  - mdStruct with lwStall: only the mdStruct outputs are asserted.
  - Counter reaching 0 while mdStartEX is pending: the FSM goes IDLE that edge. The start is accepted on the next cycle.
- stallCount saturates at 2^CNT_W−1 and does not wrap.

## Configuration
- `HAZARD_STALL_CNT_EN` defined: stallCount increments on every cycle with stallFE = 1, saturating. Reset clears it.
- Not defined: the counter is not built and stallCount is tied to 0.

## Test plan
- Forwarding: writeRegMEM = writeRegWB = rsEX = 7, regWriteMEM = regWriteWB = 1 → forwardAEX = 10. Then rsEX = writeRegMEM = 0 → forwardAEX = 00 and forwardAID = 0.
- Load-use: memToRegEX = 1, writeRegEX = rtID = 9 → stallFE = stallID = flushEX = 1, stallEX = 0 for one cycle. Change rtID to 0 → no stall.
- Branch: branchID = 1, regWriteEX = 1, writeRegEX = rsID = 3 → front stall asserted. Same stimulus with jumpRegID = 1 and rtID = 3 only → no stall.
- Mult/div, MD_LATENCY = 4:
  - Start at cycle 0 → mdBusy = 1 on cycles 1–3.
  - mdReadID during cycles 1–3 → stallFE = 1. Released at cycle 4.
  - Second start at cycle 2 → stallEX = 1 and flushMEM = 1 on cycles 2–3, accepted at cycle 4.
- Memory wait: memReqMEM = 1 with memReadyMEM = 0 for 3 cycles, lwStall also active → stallFE/ID/EX/MEM = 1, flushWB = 1, flushEX = 0. Release when memReadyMEM = 1.
- Reset/counter: with HAZARD_STALL_CNT_EN and CNT_W = 2, hold a stall 5 cycles → stallCount = 3. Assert reset mid-BUSY → mdBusy = 0 and stallCount = 0 the next cycle.

Source files
------------

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the five-stage MIPS pipe: forwarding selects, stall/flush control and a
// mult/div busy tracker. Define HAZARD_STALL_CNT_EN to build the saturating stall-cycle counter.
module hazard_unit_mc #(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branchID,
  input  logic             jumpRegID,
  input  logic [REG_W-1:0] rsID,
  input  logic [REG_W-1:0] rtID,
  input  logic [REG_W-1:0] rsEX,
  input  logic [REG_W-1:0] rtEX,
  input  logic [REG_W-1:0] writeRegEX,
  input  logic [REG_W-1:0] writeRegMEM,
  input  logic [REG_W-1:0] writeRegWB,
  input  logic             memToRegEX,
  input  logic             memToRegMEM,
  input  logic             regWriteEX,
  input  logic             regWriteMEM,
  input  logic             regWriteWB,
  input  logic             mdStartEX,
  input  logic             mdReadID,
  input  logic             memReqMEM,
  input  logic             memReadyMEM,
  output logic             stallFE,
  output logic             stallID,
  output logic             stallEX,
  output logic             stallMEM,
  output logic             flushEX,
  output logic             flushMEM,
  output logic             flushWB,
  output logic             forwardAID,
  output logic             forwardBID,
  output logic [1:0]       forwardAEX,
  output logic [1:0]       forwardBEX,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount
);

  localparam int unsigned MdCntW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam logic [MdCntW-1:0] MdLoad = MdCntW'(MD_LATENCY - 1);

  typedef enum logic {StIdle, StBusy} md_state_e;

  md_state_e         md_state_q, md_state_d;
  logic [MdCntW-1:0] md_cnt_q, md_cnt_d;

  logic md_busy;
  logic mem_stall, md_struct, lw_stall, branch_stall, md_read_stall, front_stall;
  logic rs_id_nz, rt_id_nz, rs_ex_nz, rt_ex_nz, wr_ex_nz, wr_mem_nz, wr_wb_nz;
  logic rs_ex_hit, rt_ex_hit, rs_mem_ld_hit, rt_mem_ld_hit;

  assign md_busy = (md_state_q == StBusy);
  assign mdBusy  = md_busy;

  assign rs_id_nz  = (rsID != '0);
  assign rt_id_nz  = (rtID != '0);
  assign rs_ex_nz  = (rsEX != '0);
  assign rt_ex_nz  = (rtEX != '0);
  assign wr_ex_nz  = (writeRegEX != '0);
  assign wr_mem_nz = (writeRegMEM != '0);
  assign wr_wb_nz  = (writeRegWB != '0);

  // ID comparator operands only ever come from MEM; WB is already written back by then.
  assign forwardAID = regWriteMEM && rs_id_nz && (rsID == writeRegMEM);
  assign forwardBID = regWriteMEM && rt_id_nz && (rtID == writeRegMEM);

  always_comb begin
    forwardAEX = 2'b00;
    if (regWriteMEM && rs_ex_nz && (rsEX == writeRegMEM)) begin
      forwardAEX = 2'b10;
    end else if (regWriteWB && rs_ex_nz && wr_wb_nz && (rsEX == writeRegWB)) begin
      forwardAEX = 2'b01;
    end
  end

  always_comb begin
    forwardBEX = 2'b00;
    if (regWriteMEM && rt_ex_nz && (rtEX == writeRegMEM)) begin
      forwardBEX = 2'b10;
    end else if (regWriteWB && rt_ex_nz && wr_wb_nz && (rtEX == writeRegWB)) begin
      forwardBEX = 2'b01;
    end
  end

  assign mem_stall = memReqMEM && !memReadyMEM;
  assign md_struct = mdStartEX && md_busy;

  assign lw_stall = memToRegEX && wr_ex_nz && ((writeRegEX == rsID) || (writeRegEX == rtID));

  // Branch operands resolve in ID, so a producer still in EX, or a load in MEM, must wait.
  assign rs_ex_hit     = regWriteEX && rs_id_nz && (rsID == writeRegEX);
  assign rt_ex_hit     = regWriteEX && rt_id_nz && (rtID == writeRegEX);
  assign rs_mem_ld_hit = memToRegMEM && rs_id_nz && wr_mem_nz && (rsID == writeRegMEM);
  assign rt_mem_ld_hit = memToRegMEM && rt_id_nz && wr_mem_nz && (rtID == writeRegMEM);

  assign branch_stall = ((branchID || jumpRegID) && (rs_ex_hit || rs_mem_ld_hit)) ||
                        (branchID && (rt_ex_hit || rt_mem_ld_hit));

  assign md_read_stall = mdReadID && md_busy;
  assign front_stall   = lw_stall || branch_stall || md_read_stall;

  // Priority: memory wait freezes everything, then the mult/div structural hazard, then ID.
  always_comb begin
    stallFE  = 1'b0;
    stallID  = 1'b0;
    stallEX  = 1'b0;
    stallMEM = 1'b0;
    flushEX  = 1'b0;
    flushMEM = 1'b0;
    flushWB  = 1'b0;
    if (mem_stall) begin
      stallFE  = 1'b1;
      stallID  = 1'b1;
      stallEX  = 1'b1;
      stallMEM = 1'b1;
      flushWB  = 1'b1;
    end else if (md_struct) begin
      stallFE  = 1'b1;
      stallID  = 1'b1;
      stallEX  = 1'b1;
      flushMEM = 1'b1;
    end else if (front_stall) begin
      stallFE  = 1'b1;
      stallID  = 1'b1;
      flushEX  = 1'b1;
    end
  end

  // The unit keeps computing while the pipe waits on memory, so BUSY counts down regardless.
  always_comb begin
    md_state_d = md_state_q;
    md_cnt_d   = md_cnt_q;
    case (md_state_q)
      StIdle: begin
        if (mdStartEX && !stallEX) begin
          md_state_d = StBusy;
          md_cnt_d   = MdLoad;
        end
      end
      StBusy: begin
        md_cnt_d = md_cnt_q - MdCntW'(1);
        if (md_cnt_q == MdCntW'(1)) begin
          md_state_d = StIdle;
        end
      end
      default: begin
        md_state_d = StIdle;
        md_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_state_q <= StIdle;
      md_cnt_q   <= '0;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallFE && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
`else
  assign stallCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: expected outputs are queued at drive time from a
// behavioural model and compared against the DUT at the falling edge.
module tb_hazard_unit_mc;

  localparam int unsigned REG_W      = 5;
  localparam int unsigned MD_LATENCY = 4;
  localparam int unsigned CNT_W      = 2;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             branchID, jumpRegID;
  logic [REG_W-1:0] rsID, rtID, rsEX, rtEX, writeRegEX, writeRegMEM, writeRegWB;
  logic             memToRegEX, memToRegMEM, regWriteEX, regWriteMEM, regWriteWB;
  logic             mdStartEX, mdReadID, memReqMEM, memReadyMEM;
  logic             stallFE, stallID, stallEX, stallMEM, flushEX, flushMEM, flushWB;
  logic             forwardAID, forwardBID, mdBusy;
  logic [1:0]       forwardAEX, forwardBEX;
  logic [CNT_W-1:0] stallCount;

  int n_checks = 0;
  int n_errors = 0;
  int md_left  = 0;
  int sc_model = 0;

  logic [13:0] q_ctl[$];
  int          q_cnt[$];
  string       q_tag[$];

  always #5 clk = ~clk;

  hazard_unit_mc #(
    .REG_W     (REG_W),
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .branchID   (branchID),
    .jumpRegID  (jumpRegID),
    .rsID       (rsID),
    .rtID       (rtID),
    .rsEX       (rsEX),
    .rtEX       (rtEX),
    .writeRegEX (writeRegEX),
    .writeRegMEM(writeRegMEM),
    .writeRegWB (writeRegWB),
    .memToRegEX (memToRegEX),
    .memToRegMEM(memToRegMEM),
    .regWriteEX (regWriteEX),
    .regWriteMEM(regWriteMEM),
    .regWriteWB (regWriteWB),
    .mdStartEX  (mdStartEX),
    .mdReadID   (mdReadID),
    .memReqMEM  (memReqMEM),
    .memReadyMEM(memReadyMEM),
    .stallFE    (stallFE),
    .stallID    (stallID),
    .stallEX    (stallEX),
    .stallMEM   (stallMEM),
    .flushEX    (flushEX),
    .flushMEM   (flushMEM),
    .flushWB    (flushWB),
    .forwardAID (forwardAID),
    .forwardBID (forwardBID),
    .forwardAEX (forwardAEX),
    .forwardBEX (forwardBEX),
    .mdBusy     (mdBusy),
    .stallCount (stallCount)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic ld_or_ex_hit(input logic [REG_W-1:0] a);
    if (a == 0) return 1'b0;
    return (regWriteEX && a == writeRegEX) || (memToRegMEM && a == writeRegMEM);
  endfunction

  function automatic logic [1:0] ex_src(input logic [REG_W-1:0] a);
    if (a == 0) return 2'b00;
    if (regWriteMEM && a == writeRegMEM) return 2'b10;
    if (regWriteWB && a == writeRegWB) return 2'b01;
    return 2'b00;
  endfunction

  // {sFE,sID,sEX,sMEM,fEX,fMEM,fWB,fAID,fBID,fAEX[1:0],fBEX[1:0],busy}
  function automatic logic [13:0] model_ctl();
    logic       busy, lw, br, ms, mst;
    logic [6:0] sf;
    busy = (md_left > 0);
    ms   = memReqMEM && !memReadyMEM;
    mst  = mdStartEX && busy;
    lw   = memToRegEX && (writeRegEX != 0) && (writeRegEX == rsID || writeRegEX == rtID);
    br   = 1'b0;
    if (branchID) br = ld_or_ex_hit(rsID) || ld_or_ex_hit(rtID);
    else if (jumpRegID) br = ld_or_ex_hit(rsID);
    if (ms)                             sf = 7'b1111001;
    else if (mst)                       sf = 7'b1110010;
    else if (lw || br || (mdReadID && busy)) sf = 7'b1100100;
    else                                sf = 7'b0000000;
    return {sf,
            regWriteMEM && rsID != 0 && rsID == writeRegMEM,
            regWriteMEM && rtID != 0 && rtID == writeRegMEM,
            ex_src(rsEX), ex_src(rtEX), busy};
  endfunction

  task automatic cycle(input string tag);
    logic [13:0] e;
    string       t;
    e = model_ctl();
    q_ctl.push_back(e);
    q_cnt.push_back(sc_model);
    q_tag.push_back(tag);
    @(negedge clk);
    t = q_tag.pop_front();
    check_eq({t, "_ctl"},
             {18'd0, stallFE, stallID, stallEX, stallMEM, flushEX, flushMEM, flushWB,
              forwardAID, forwardBID, forwardAEX, forwardBEX, mdBusy},
             {18'd0, q_ctl.pop_front()});
    check_eq({t, "_cnt"}, {30'd0, stallCount}, q_cnt.pop_front());
    @(posedge clk);
    if (reset) begin
      md_left  = 0;
      sc_model = 0;
    end else begin
      if (md_left > 0) md_left--;
      else if (mdStartEX && !e[11]) md_left = MD_LATENCY - 1;
`ifdef HAZARD_STALL_CNT_EN
      if (e[13] && sc_model < CNT_MAX) sc_model++;
`endif
    end
    #1;
  endtask

  task automatic clear_inputs();
    reset = 0; branchID = 0; jumpRegID = 0;
    rsID = 0; rtID = 0; rsEX = 0; rtEX = 0;
    writeRegEX = 0; writeRegMEM = 0; writeRegWB = 0;
    memToRegEX = 0; memToRegMEM = 0; regWriteEX = 0; regWriteMEM = 0; regWriteWB = 0;
    mdStartEX = 0; mdReadID = 0; memReqMEM = 0; memReadyMEM = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    cycle("rst");
    reset = 0;
    cycle("idle");

    // Forwarding, MEM wins over WB, r0 never forwarded
    writeRegMEM = 7; writeRegWB = 7; rsEX = 7; regWriteMEM = 1; regWriteWB = 1;
    cycle("fwd_mem");
    rtEX = 7; regWriteMEM = 0;
    cycle("fwd_wb");
    regWriteMEM = 1; rsID = 7; rtID = 7;
    cycle("fwd_id");
    rsEX = 0; rtEX = 0; writeRegMEM = 0; writeRegWB = 0; rsID = 0; rtID = 0;
    cycle("fwd_r0");
    clear_inputs();

    // Load-use
    memToRegEX = 1; writeRegEX = 9; rtID = 9;
    cycle("lw");
    rtID = 0; writeRegEX = 0;
    cycle("lw_r0");
    clear_inputs();

    // Branch / jr
    branchID = 1; regWriteEX = 1; writeRegEX = 3; rsID = 3;
    cycle("br_rs");
    branchID = 0; jumpRegID = 1; rsID = 0; rtID = 3;
    cycle("jr_rt");
    jumpRegID = 0; branchID = 1; regWriteEX = 0; memToRegMEM = 1; writeRegMEM = 4; rtID = 4;
    cycle("br_ld");
    clear_inputs();

    // Mult/div: start at cycle 0, mfhi during busy, second start held until idle
    mdStartEX = 1;
    cycle("md_c0");
    mdStartEX = 0; mdReadID = 1;
    cycle("md_c1");
    mdReadID = 0; mdStartEX = 1;
    cycle("md_c2");
    memToRegEX = 1; writeRegEX = 5; rsID = 5;
    cycle("md_c3_lw");
    memToRegEX = 0; writeRegEX = 0; rsID = 0;
    cycle("md_c4_acc");
    mdStartEX = 0; mdReadID = 1;
    for (int i = 0; i < 4; i++) cycle($sformatf("md_rd%0d", i));
    clear_inputs();

    // Memory wait with a load-use in flight
    memReqMEM = 1; memToRegEX = 1; writeRegEX = 9; rtID = 9;
    for (int i = 0; i < 3; i++) cycle($sformatf("mem_wait%0d", i));
    memReadyMEM = 1;
    cycle("mem_rel");
    clear_inputs();

    // Mult/div keeps counting through a memory wait
    mdStartEX = 1;
    cycle("md_mw_start");
    mdStartEX = 0; memReqMEM = 1;
    for (int i = 0; i < 4; i++) cycle($sformatf("md_mw%0d", i));
    clear_inputs();

    // Stall counter saturation, then reset mid-BUSY
    memToRegEX = 1; writeRegEX = 2; rsID = 2;
    for (int i = 0; i < 5; i++) cycle($sformatf("sat%0d", i));
    clear_inputs();
    mdStartEX = 1;
    cycle("rb_start");
    mdStartEX = 0;
    cycle("rb_busy");
    reset = 1;
    cycle("rb_reset");
    reset = 0;
    cycle("rb_after");

    // Random traffic over a small register set
    for (int i = 0; i < 300; i++) begin
      reset       = ($urandom_range(0, 49) == 0);
      branchID    = ($urandom_range(0, 3) == 0);
      jumpRegID   = ($urandom_range(0, 5) == 0);
      rsID        = REG_W'($urandom_range(0, 3));
      rtID        = REG_W'($urandom_range(0, 3));
      rsEX        = REG_W'($urandom_range(0, 3));
      rtEX        = REG_W'($urandom_range(0, 3));
      writeRegEX  = REG_W'($urandom_range(0, 3));
      writeRegMEM = REG_W'($urandom_range(0, 3));
      writeRegWB  = REG_W'($urandom_range(0, 3));
      memToRegEX  = ($urandom_range(0, 3) == 0);
      memToRegMEM = ($urandom_range(0, 3) == 0);
      regWriteEX  = $urandom_range(0, 1) != 0;
      regWriteMEM = $urandom_range(0, 1) != 0;
      regWriteWB  = $urandom_range(0, 1) != 0;
      mdStartEX   = ($urandom_range(0, 3) == 0);
      mdReadID    = ($urandom_range(0, 3) == 0);
      memReqMEM   = ($urandom_range(0, 2) == 0);
      memReadyMEM = $urandom_range(0, 1) != 0;
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
